// File: rtl/sram_access_arbiter.sv
// Shared 64K x 8 SRAM arbiter: round-robin between CP and Pi single-byte accesses,
// sequencing SETUP / strobe / HOLD / ACK with every output driven from a flop.
module sram_access_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int ADDR_W        = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cp_req,
   input  logic              cp_we,
   input  logic [ADDR_W-1:0] cp_addr,
   input  logic [7:0]        cp_wdata,
   output logic              cp_ack,
   output logic [7:0]        cp_rdata,
   input  logic              pi_req,
   input  logic              pi_we,
   input  logic [ADDR_W-1:0] pi_addr,
   input  logic [7:0]        pi_wdata,
   output logic              pi_ack,
   output logic [7:0]        pi_rdata,
   output logic [ADDR_W-1:0] RAM_A,
   output logic              RAM_OE_n,
   output logic              RAM_WE_n,
   output logic [7:0]        ram_dout,
   output logic              ram_doe,
   input  logic [7:0]        ram_din,
   output logic              owner,
   output logic              busy
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_ACK} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              last_owner_q, last_owner_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_doe_q, ram_doe_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              cp_ack_q, cp_ack_d;
   logic              pi_ack_q, pi_ack_d;
   logic [7:0]        cp_rdata_q, cp_rdata_d;
   logic [7:0]        pi_rdata_q, pi_rdata_d;
   logic              grant_pi;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      we_d         = we_q;
      last_owner_d = last_owner_q;
      busy_d       = busy_q;
      ram_a_d      = ram_a_q;
      ram_dout_d   = ram_dout_q;
      ram_doe_d    = ram_doe_q;
      oe_n_d       = oe_n_q;
      we_n_d       = we_n_q;
      cp_ack_d     = 1'b0;
      pi_ack_d     = 1'b0;
      cp_rdata_d   = cp_rdata_q;
      pi_rdata_d   = pi_rdata_q;
      grant_pi     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cp_req || pi_req) begin
               // On a tie the side that did not go last wins.
               grant_pi   = pi_req && (!cp_req || !last_owner_q);
               owner_d    = grant_pi;
               we_d       = grant_pi ? pi_we    : cp_we;
               ram_a_d    = grant_pi ? pi_addr  : cp_addr;
               ram_dout_d = grant_pi ? pi_wdata : cp_wdata;
               ram_doe_d  = we_d;
               busy_d     = 1'b1;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            oe_n_d  = we_q;
            we_n_d  = !we_q;
            cnt_d   = CNT_LOAD;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               state_d = S_HOLD;
               // The read byte is taken on the edge that ends the strobe.
               if (!we_q) begin
                  if (owner_q) pi_rdata_d = ram_din;
                  else         cp_rdata_d = ram_din;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            ram_doe_d = 1'b0;
            cp_ack_d  = !owner_q;
            pi_ack_d  = owner_q;
            state_d   = S_ACK;
         end
         S_ACK: begin
            last_owner_d = owner_q;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         last_owner_q <= 1'b1;
         busy_q       <= 1'b0;
         ram_a_q      <= '0;
         ram_dout_q   <= 8'h00;
         ram_doe_q    <= 1'b0;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         cp_ack_q     <= 1'b0;
         pi_ack_q     <= 1'b0;
         cp_rdata_q   <= 8'h00;
         pi_rdata_q   <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         last_owner_q <= last_owner_d;
         busy_q       <= busy_d;
         ram_a_q      <= ram_a_d;
         ram_dout_q   <= ram_dout_d;
         ram_doe_q    <= ram_doe_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         cp_ack_q     <= cp_ack_d;
         pi_ack_q     <= pi_ack_d;
         cp_rdata_q   <= cp_rdata_d;
         pi_rdata_q   <= pi_rdata_d;
      end
   end

   assign RAM_A    = ram_a_q;
   assign RAM_OE_n = oe_n_q;
   assign RAM_WE_n = we_n_q;
   assign ram_dout = ram_dout_q;
   assign ram_doe  = ram_doe_q;
   assign cp_ack   = cp_ack_q;
   assign pi_ack   = pi_ack_q;
   assign cp_rdata = cp_rdata_q;
   assign pi_rdata = pi_rdata_q;
   assign owner    = owner_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM model on the bus, queued CP/Pi requesters and
// an order/data reference model derived from the round-robin and latency rules.
module tb_sram_access_arbiter;
   parameter int AC = 2;

   typedef struct packed {logic we; logic [15:0] addr; logic [7:0] wdata;} op_t;
   typedef struct {bit side; bit ack_pi; bit both_ack; bit other_chg; int lat;
                   int oe_cnt; int we_cnt; int doe_cnt; bit bad_addr; bit bad_dout;
                   logic [7:0] rdata;} rec_t;
   typedef struct {bit side; bit we; logic [7:0] rdata;} exp_t;

   logic CLK, RESET;
   logic cp_req, cp_we, cp_ack, pi_req, pi_we, pi_ack;
   logic [15:0] cp_addr, pi_addr, RAM_A;
   logic [7:0] cp_wdata, cp_rdata, pi_wdata, pi_rdata, ram_dout, ram_din;
   logic RAM_OE_n, RAM_WE_n, ram_doe, owner, busy;

   int tests_run, tests_failed, viol, gaps;
   op_t cp_ops[$], pi_ops[$];
   rec_t recs[$];
   exp_t exp_q[$];
   bit model_last;
   logic [7:0] model_rd [2];
   logic [7:0] ref_mem [0:65535];
   bit ref_wr [0:65535];
   logic [7:0] mem [0:65535];
   bit mem_wr [0:65535];
   logic prev_strobe;
   logic [15:0] prev_a;

   sram_access_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(16)) dut (
      .CLK(CLK), .RESET(RESET),
      .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
      .cp_ack(cp_ack), .cp_rdata(cp_rdata),
      .pi_req(pi_req), .pi_we(pi_we), .pi_addr(pi_addr), .pi_wdata(pi_wdata),
      .pi_ack(pi_ack), .pi_rdata(pi_rdata),
      .RAM_A(RAM_A), .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n),
      .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_din(ram_din),
      .owner(owner), .busy(busy));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] bg(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // SRAM model: latches on a low WE_n edge, drives D mid-cycle, junk when OE_n is high.
   always @(posedge CLK)
      if (!RAM_WE_n && ram_doe) begin
         mem[RAM_A]    <= ram_dout;
         mem_wr[RAM_A] <= 1'b1;
      end
   always @(negedge CLK)
      ram_din <= RAM_OE_n ? 8'($urandom) : (mem_wr[RAM_A] ? mem[RAM_A] : bg(RAM_A));

   always @(negedge CLK) begin
      if (!RAM_OE_n && !RAM_WE_n) viol <= viol + 1;
      if (ram_doe && (!busy || !RAM_OE_n)) viol <= viol + 1;
      if ((!RAM_OE_n || !RAM_WE_n) && prev_strobe && RAM_A !== prev_a) viol <= viol + 1;
      prev_strobe <= !RAM_OE_n || !RAM_WE_n;
      prev_a      <= RAM_A;
   end

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_wr[a] ? ref_mem[a] : bg(a);
   endfunction

   // Expected service order and results for the queued ops, both sides requesting
   // from the same edge and re-requesting immediately while they have work.
   function automatic void predict();
      int c = 0, p = 0;
      bit s;
      op_t o;
      exp_t e;
      exp_q.delete();
      while (c < cp_ops.size() || p < pi_ops.size()) begin
         if (c < cp_ops.size() && p < pi_ops.size()) s = !model_last;
         else s = (p < pi_ops.size());
         if (s) begin o = pi_ops[p]; p++; end
         else   begin o = cp_ops[c]; c++; end
         if (o.we) begin ref_mem[o.addr] = o.wdata; ref_wr[o.addr] = 1'b1; end
         else model_rd[s] = ref_rd(o.addr);
         e.side = s; e.we = o.we; e.rdata = model_rd[s];
         exp_q.push_back(e);
         model_last = s;
      end
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; cp_req = 1'b0; pi_req = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      model_last = 1'b1; model_rd[0] = 8'h00; model_rd[1] = 8'h00;
   endtask

   task automatic run_traffic(input bit scramble);
      int k = 0, n = 0, limit;
      bit active = 0;
      rec_t r;
      op_t cur;
      logic [7:0] oth;
      limit = (cp_ops.size() + pi_ops.size() + 1) * (AC + 10);
      recs.delete(); gaps = 0; cur = '0; oth = 8'h00; r = '{default: 0};
      if (cp_ops.size() > 0) begin cp_req = 1'b1; {cp_we, cp_addr, cp_wdata} = cp_ops[0]; end
      if (pi_ops.size() > 0) begin pi_req = 1'b1; {pi_we, pi_addr, pi_wdata} = pi_ops[0]; end
      while ((cp_req || pi_req) && n < limit) begin
         @(negedge CLK); n++;
         if (!busy && (cp_req || pi_req)) gaps++;
         if (!active && busy) begin
            active = 1; k = 0; r = '{default: 0}; r.side = owner;
            if (owner && pi_ops.size() > 0) cur = pi_ops[0];
            else if (!owner && cp_ops.size() > 0) cur = cp_ops[0];
            oth = owner ? cp_rdata : pi_rdata;
         end else if (active) k++;
         if (active) begin
            if (!RAM_OE_n) r.oe_cnt++;
            if (!RAM_WE_n) r.we_cnt++;
            if (ram_doe) r.doe_cnt++;
            if (RAM_A !== cur.addr) r.bad_addr = 1;
            if (ram_doe && ram_dout !== cur.wdata) r.bad_dout = 1;
            if (scramble && k == 1) begin
               if (r.side) {pi_we, pi_addr, pi_wdata} = 25'($urandom);
               else        {cp_we, cp_addr, cp_wdata} = 25'($urandom);
            end
            if (cp_ack || pi_ack) begin
               r.lat = k; r.ack_pi = pi_ack; r.both_ack = cp_ack && pi_ack;
               r.rdata = r.side ? pi_rdata : cp_rdata;
               r.other_chg = ((r.side ? cp_rdata : pi_rdata) !== oth);
               recs.push_back(r); active = 0;
               if (pi_ack && pi_ops.size() > 0) begin
                  void'(pi_ops.pop_front());
                  if (pi_ops.size() > 0) {pi_we, pi_addr, pi_wdata} = pi_ops[0];
                  else pi_req = 1'b0;
               end else if (cp_ack && cp_ops.size() > 0) begin
                  void'(cp_ops.pop_front());
                  if (cp_ops.size() > 0) {cp_we, cp_addr, cp_wdata} = cp_ops[0];
                  else cp_req = 1'b0;
               end
            end
         end
      end
      if (n >= limit) begin
         tests_run++; tests_failed++;
         $display("FAIL traffic_timeout: no completion after %0d cycles", n);
         cp_req = 1'b0; pi_req = 1'b0; cp_ops.delete(); pi_ops.delete();
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      @(negedge CLK); @(negedge CLK);
      tests_run++;
      if ({RAM_OE_n, RAM_WE_n, ram_doe} !== 3'b110) begin
         tests_failed++; $display("FAIL reset_strobes: got %b want 110", {RAM_OE_n, RAM_WE_n, ram_doe});
      end
      tests_run++;
      if ({RAM_A, ram_dout} !== 24'h0) begin
         tests_failed++; $display("FAIL reset_bus: got %h want 000000", {RAM_A, ram_dout});
      end
      tests_run++;
      if ({cp_ack, pi_ack, cp_rdata, pi_rdata} !== 18'h0) begin
         tests_failed++; $display("FAIL reset_resp: got %h want 0", {cp_ack, pi_ack, cp_rdata, pi_rdata});
      end
      tests_run++;
      if ({owner, busy} !== 2'b00) begin
         tests_failed++; $display("FAIL reset_state: got %b want 00", {owner, busy});
      end
      RESET = 1'b0;
      model_last = 1'b1; model_rd[0] = 8'h00; model_rd[1] = 8'h00;
   endtask

   task automatic test_cp_write();
      cp_ops.push_back('{we: 1'b1, addr: 16'h1122, wdata: 8'hAA});
      predict(); run_traffic(1'b0);
      tests_run++;
      if (recs.size() != 1) begin
         tests_failed++; $display("FAIL cpw_count: got %0d want 1", recs.size());
      end else begin
         tests_run++;
         if ({recs[0].side, recs[0].ack_pi, recs[0].both_ack, 8'(recs[0].lat)} !== {3'b000, 8'(AC + 2)}) begin
            tests_failed++; $display("FAIL cpw_ack: side/ack_pi/both/lat %b%b%b/%0d want 000/%0d",
               recs[0].side, recs[0].ack_pi, recs[0].both_ack, recs[0].lat, AC + 2);
         end
         tests_run++;
         if ({8'(recs[0].we_cnt), 8'(recs[0].oe_cnt), 8'(recs[0].doe_cnt), recs[0].bad_addr, recs[0].bad_dout}
             !== {8'(AC), 8'd0, 8'(AC + 2), 2'b00}) begin
            tests_failed++; $display("FAIL cpw_strobes: we=%0d oe=%0d doe=%0d ba=%b bd=%b want %0d 0 %0d 0 0",
               recs[0].we_cnt, recs[0].oe_cnt, recs[0].doe_cnt, recs[0].bad_addr, recs[0].bad_dout, AC, AC + 2);
         end
      end
      tests_run++;
      if (mem[16'h1122] !== 8'hAA) begin
         tests_failed++; $display("FAIL cpw_sram: got %h want aa", mem[16'h1122]);
      end
   endtask

   task automatic test_cp_read();
      cp_ops.push_back('{we: 1'b0, addr: 16'h1122, wdata: 8'h00});
      predict(); run_traffic(1'b0);
      tests_run++;
      if (recs.size() != 1) begin
         tests_failed++; $display("FAIL cpr_count: got %0d want 1", recs.size());
      end else begin
         tests_run++;
         if ({recs[0].side, recs[0].ack_pi, 8'(recs[0].lat), recs[0].rdata, recs[0].other_chg}
             !== {2'b00, 8'(AC + 2), 8'hAA, 1'b0}) begin
            tests_failed++; $display("FAIL cpr_result: side=%b lat=%0d rdata=%h oth=%b want 0 %0d aa 0",
               recs[0].side, recs[0].lat, recs[0].rdata, recs[0].other_chg, AC + 2);
         end
         tests_run++;
         if ({8'(recs[0].oe_cnt), 8'(recs[0].we_cnt), 8'(recs[0].doe_cnt), recs[0].bad_addr} !== {8'(AC), 16'd0, 1'b0}) begin
            tests_failed++; $display("FAIL cpr_strobes: oe=%0d we=%0d doe=%0d ba=%b want %0d 0 0 0",
               recs[0].oe_cnt, recs[0].we_cnt, recs[0].doe_cnt, recs[0].bad_addr, AC);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cp_ops.push_back('{we: 1'b1, addr: 16'h0001, wdata: 8'h11});
      pi_ops.push_back('{we: 1'b1, addr: 16'h0002, wdata: 8'h22});
      predict(); run_traffic(1'b0);
      tests_run++;
      if (recs.size() != 2 || recs[0].side !== 1'b0 || recs[1].side !== 1'b1) begin
         tests_failed++; $display("FAIL sim_order: got %0d accesses, first side %b want 2 accesses CP then Pi",
            recs.size(), recs.size() > 0 ? recs[0].side : 1'bx);
      end
      cp_ops.push_back('{we: 1'b0, addr: 16'h0001, wdata: 8'h00});
      pi_ops.push_back('{we: 1'b0, addr: 16'h0002, wdata: 8'h00});
      predict(); run_traffic(1'b0);
      for (int i = 0; i < recs.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if ({recs[i].side, recs[i].ack_pi, recs[i].other_chg, recs[i].rdata} !== {exp_q[i].side, exp_q[i].side, 1'b0, exp_q[i].rdata}) begin
            tests_failed++; $display("FAIL sim_read[%0d]: side=%b oth=%b rdata=%h want side=%b oth=0 rdata=%h",
               i, recs[i].side, recs[i].other_chg, recs[i].rdata, exp_q[i].side, exp_q[i].rdata);
         end
      end
      tests_run++;
      if ({cp_rdata, pi_rdata} !== 16'h1122) begin
         tests_failed++; $display("FAIL sim_rdata: got cp=%h pi=%h want cp=11 pi=22", cp_rdata, pi_rdata);
      end
   endtask

   task automatic test_alternation();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cp_ops.push_back('{we: 1'($urandom), addr: 16'(i), wdata: 8'($urandom)});
         pi_ops.push_back('{we: 1'($urandom), addr: 16'(i + 4), wdata: 8'($urandom)});
      end
      predict(); run_traffic(1'b0);
      tests_run++;
      if (recs.size() != 6 || gaps != 5) begin
         tests_failed++; $display("FAIL alt_shape: accesses=%0d idle_gaps=%0d want 6 and 5", recs.size(), gaps);
      end
      for (int i = 0; i < recs.size() && i < 6; i++) begin
         tests_run++;
         if ({recs[i].side, recs[i].both_ack, recs[i].rdata} !== {1'(i % 2), 1'b0, exp_q[i].rdata}) begin
            tests_failed++; $display("FAIL alt_owner[%0d]: side=%b both=%b rdata=%h want side=%0d both=0 rdata=%h",
               i, recs[i].side, recs[i].both_ack, recs[i].rdata, i % 2, exp_q[i].rdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      pi_ops.push_back('{we: 1'b1, addr: 16'h0300, wdata: 8'h5C});
      pi_ops.push_back('{we: 1'b0, addr: 16'h0300, wdata: 8'h00});
      predict(); run_traffic(1'b0);
      pi_req = 1'b1; {pi_we, pi_addr, pi_wdata} = {1'b1, 16'h0400, 8'h99};
      @(negedge CLK);
      cp_req = 1'b1; {cp_we, cp_addr, cp_wdata} = {1'b0, 16'h0300, 8'h00};
      @(negedge CLK);
      tests_run++;
      if ({RAM_WE_n, ram_doe, pi_rdata} !== {2'b01, 8'h5C}) begin
         tests_failed++; $display("FAIL mid_pre: we_n=%b doe=%b pi_rdata=%h want 0 1 5c", RAM_WE_n, ram_doe, pi_rdata);
      end
      #2 RESET = 1'b1;
      #1;
      tests_run++;
      if ({RAM_WE_n, ram_doe, busy, pi_ack, pi_rdata, cp_rdata} !== {4'b1000, 16'h0}) begin
         tests_failed++; $display("FAIL mid_reset: we_n=%b doe=%b busy=%b pi_ack=%b rd=%h/%h want 1 0 0 0 00/00",
            RAM_WE_n, ram_doe, busy, pi_ack, pi_rdata, cp_rdata);
      end
      pi_req = 1'b0;
      @(negedge CLK);
      tests_run++;
      if ({pi_ack, cp_ack} !== 2'b00) begin
         tests_failed++; $display("FAIL mid_noack: pi_ack=%b cp_ack=%b want 0 0", pi_ack, cp_ack);
      end
      RESET = 1'b0;
      model_last = 1'b1; model_rd[0] = 8'h00; model_rd[1] = 8'h00;
      cp_ops.push_back('{we: 1'b0, addr: 16'h0300, wdata: 8'h00});
      predict(); run_traffic(1'b0);
      tests_run++;
      if (recs.size() != 1 || {recs[0].side, 8'(recs[0].lat), recs[0].rdata} !== {1'b0, 8'(AC + 2), 8'h5C}) begin
         tests_failed++; $display("FAIL mid_after: accesses=%0d side=%b lat=%0d rdata=%h want 1 0 %0d 5c",
            recs.size(), recs.size() > 0 ? recs[0].side : 1'bx, recs.size() > 0 ? recs[0].lat : -1,
            recs.size() > 0 ? recs[0].rdata : 8'hxx, AC + 2);
      end
   endtask

   task automatic test_random();
      int nc, np;
      for (int round = 0; round < 12; round++) begin
         nc = $urandom_range(0, 3); np = $urandom_range(0, 3);
         if (nc + np == 0) nc = 1;
         for (int i = 0; i < nc; i++)
            cp_ops.push_back('{we: 1'($urandom), addr: 16'($urandom_range(0, 15)), wdata: 8'($urandom)});
         for (int i = 0; i < np; i++)
            pi_ops.push_back('{we: 1'($urandom), addr: 16'($urandom_range(0, 15)), wdata: 8'($urandom)});
         predict(); run_traffic(1'b1);
         tests_run++;
         if (recs.size() != exp_q.size() || gaps != exp_q.size() - 1) begin
            tests_failed++; $display("FAIL rnd_shape[%0d]: accesses=%0d gaps=%0d want %0d and %0d",
               round, recs.size(), gaps, exp_q.size(), exp_q.size() - 1);
         end
         for (int i = 0; i < recs.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if ({recs[i].side, recs[i].ack_pi, recs[i].both_ack, recs[i].other_chg, 8'(recs[i].lat), recs[i].rdata}
                !== {exp_q[i].side, exp_q[i].side, 2'b00, 8'(AC + 2), exp_q[i].rdata}) begin
               tests_failed++; $display("FAIL rnd_acc[%0d.%0d]: side=%b ackpi=%b both=%b oth=%b lat=%0d rd=%h want side=%b lat=%0d rd=%h",
                  round, i, recs[i].side, recs[i].ack_pi, recs[i].both_ack, recs[i].other_chg, recs[i].lat,
                  recs[i].rdata, exp_q[i].side, AC + 2, exp_q[i].rdata);
            end
            tests_run++;
            if ({8'(recs[i].oe_cnt), 8'(recs[i].we_cnt), 8'(recs[i].doe_cnt), recs[i].bad_addr, recs[i].bad_dout}
                !== {8'(exp_q[i].we ? 0 : AC), 8'(exp_q[i].we ? AC : 0), 8'(exp_q[i].we ? AC + 2 : 0), 2'b00}) begin
               tests_failed++; $display("FAIL rnd_strobe[%0d.%0d]: oe=%0d we=%0d doe=%0d ba=%b bd=%b for we=%b",
                  round, i, recs[i].oe_cnt, recs[i].we_cnt, recs[i].doe_cnt, recs[i].bad_addr,
                  recs[i].bad_dout, exp_q[i].we);
            end
         end
      end
   endtask

   task automatic test_invariants();
      tests_run++;
      if (viol !== 0) begin
         tests_failed++; $display("FAIL bus_invariants: got %0d violations want 0", viol);
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0; viol = 0; gaps = 0;
      prev_strobe = 1'b0; prev_a = 16'h0;
      RESET = 1'b1; cp_req = 1'b0; pi_req = 1'b0;
      {cp_we, cp_addr, cp_wdata} = '0; {pi_we, pi_addr, pi_wdata} = '0;
      for (int i = 0; i < 65536; i++) ref_wr[i] = 1'b0;
      test_reset();
      test_cp_write();
      test_cp_read();
      test_simultaneous();
      test_alternation();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
